fsk_framed_tx: RTL and testbench

FSK_FRAMED_TX -- requirements
Module: fsk_framed_tx

---
 rtl/fsk_pkg.sv | 19 +
 rtl/fsk_tone_gen.sv | 39 +++
 rtl/fsk_framed_tx.sv | 131 +++++++++++++
 tb/tb_fsk_framed_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared definitions for the framed FSK transmitter: frame state encoding
// and the default bit/tone timing constants.
package fsk_pkg;

  // Frame sequencer states; PARITY is only reachable when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } fsk_state_e;

  // Default timing: 160 clk per bit, mark tone period 10 clk, space tone period 20 clk.
  localparam int DEF_BIT_CYC    = 160;
  localparam int DEF_HALF_MARK  = 5;
  localparam int DEF_HALF_SPACE = 10;

endpackage

// File: rtl/fsk_tone_gen.sv
// Tone divider: squarewave whose half-period depends on the bit being sent.
// A restart pulse realigns the phase so the next cycle starts high.
module fsk_tone_gen #(
  parameter int HALF_MARK  = 5,
  parameter int HALF_SPACE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_val,
  input  logic restart,
  output logic dataout
);

  localparam int HC_W = (HALF_SPACE > 1) ? $clog2(HALF_SPACE) : 1;

  logic [HC_W-1:0] hc_reg;
  logic [HC_W-1:0] half_last;
  logic            tone_reg;

  assign half_last = bit_val ? HC_W'(HALF_MARK - 1) : HC_W'(HALF_SPACE - 1);
  assign dataout   = tone_reg;

  // Half-period counter; toggles the tone at each half-period end, restart wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc_reg   <= '0;
      tone_reg <= 1'b0;
    end else if (restart) begin
      hc_reg   <= '0;
      tone_reg <= 1'b1;
    end else if (hc_reg == half_last) begin
      hc_reg   <= '0;
      tone_reg <= ~tone_reg;
    end else begin
      hc_reg   <= hc_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fsk_framed_tx.sv
// Framed FSK transmitter: start bit, DATA_W data bits LSB first, optional
// parity bit, stop bit; each bit is BIT_CYC clk long and sent as a tone.
// Parity bit is compiled in when FSK_FRAMED_TX_PARITY_EN is defined.
module fsk_framed_tx
  import fsk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYC    = DEF_BIT_CYC,
  parameter int HALF_MARK  = DEF_HALF_MARK,
  parameter int HALF_SPACE = DEF_HALF_SPACE,
  parameter int ODD_PAR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dataout,
  output logic              busy,
  output logic              frame_done
);

  localparam int CYC_W = $clog2(BIT_CYC);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Reject timing/width combinations the tone and frame logic cannot honour.
  if (HALF_MARK < 1 || HALF_MARK >= HALF_SPACE) begin : g_bad_half
    $error("fsk_framed_tx: need 1 <= HALF_MARK < HALF_SPACE");
  end
  if (BIT_CYC < 2 * HALF_SPACE) begin : g_bad_bit_cyc
    $error("fsk_framed_tx: BIT_CYC must be at least 2*HALF_SPACE");
  end
  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
    $error("fsk_framed_tx: DATA_W must be in 1..16");
  end
  if (ODD_PAR != 0 && ODD_PAR != 1) begin : g_bad_odd_par
    $error("fsk_framed_tx: ODD_PAR must be 0 or 1");
  end

  fsk_state_e        state_reg, state_next;
  logic [CYC_W-1:0]  cyc_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] word_reg;
  logic              din_ready_reg;
  logic              accept;
  logic              bit_end;
  logic              last_data;
  logic              cur_bit;
  logic              restart;
  logic              tone;

`ifdef FSK_FRAMED_TX_PARITY_EN
  logic par_bit;
  assign par_bit = (^word_reg) ^ (ODD_PAR != 0);
`endif

  assign accept     = din_valid && din_ready_reg;
  assign bit_end    = (cyc_reg == CYC_W'(BIT_CYC - 1));
  assign last_data  = (idx_reg == IDX_W'(DATA_W - 1));
  assign busy       = (state_reg != IDLE);
  assign din_ready  = din_ready_reg;
  assign frame_done = (state_reg == STOP) && bit_end;
  // New tone phase on the first cycle of every bit, including the start bit.
  assign restart    = accept || (busy && bit_end);
  assign dataout    = tone & busy;

  // Next-state sequencing: advance one state per completed bit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = START;
      START:  if (bit_end) state_next = DATA;
`ifdef FSK_FRAMED_TX_PARITY_EN
      DATA:   if (bit_end && last_data) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:   if (bit_end && last_data) state_next = STOP;
`endif
      STOP:   if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Value of the bit currently on the line; selects the tone frequency.
  always_comb begin
    cur_bit = 1'b0;
    case (state_reg)
      DATA:   cur_bit = word_reg[idx_reg];
`ifdef FSK_FRAMED_TX_PARITY_EN
      PARITY: cur_bit = par_bit;
`endif
      STOP:   cur_bit = 1'b1;
      default: cur_bit = 1'b0;
    endcase
  end

  // State, bit-cycle counter, data index and word latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cyc_reg       <= '0;
      idx_reg       <= '0;
      word_reg      <= '0;
      din_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // Ready is registered so it first rises one edge after reset release.
      din_ready_reg <= (state_next == IDLE);
      if (accept) begin
        word_reg <= datain;
        cyc_reg  <= '0;
        idx_reg  <= '0;
      end else if (busy) begin
        cyc_reg <= bit_end ? '0 : cyc_reg + 1'b1;
        if (state_reg == DATA && bit_end) idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  fsk_tone_gen #(
    .HALF_MARK  (HALF_MARK),
    .HALF_SPACE (HALF_SPACE)
  ) u_tone (
    .clk     (clk),
    .reset   (reset),
    .bit_val (cur_bit),
    .restart (restart),
    .dataout (tone)
  );

endmodule

// File: tb/tb_fsk_framed_tx.sv
// Testbench for fsk_framed_tx: the expected waveform of each frame is built
// from the frame layout and tone half-periods with plain arithmetic.
module tb_fsk_framed_tx;

  localparam int DW = 8;
  localparam int BC = 160;
  localparam int HM = 5;
  localparam int HS = 10;
`ifdef FSK_FRAMED_TX_PARITY_EN
  localparam int PAR_EN = 1;
  localparam int ODD    = 0;
`else
  localparam int PAR_EN = 0;
  localparam int ODD    = 1;
`endif
  localparam int NBITS     = DW + 2 + PAR_EN;
  localparam int FRAME_CYC = NBITS * BC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] datain = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          dataout;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsk_framed_tx #(
    .DATA_W     (DW),
    .BIT_CYC    (BC),
    .HALF_MARK  (HM),
    .HALF_SPACE (HS),
    .ODD_PAR    (ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .datain     (datain),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dataout    (dataout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Bit idx of the frame for word w: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (PAR_EN != 0 && idx == DW + 1) return (^w) ^ (ODD != 0);
    return 1'b1;
  endfunction

  // Tone level k cycles into a bit: high in even half-periods.
  function automatic logic exp_tone(input logic b, input int k);
    int h;
    h = b ? HM : HS;
    return ((k / h) % 2) == 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [DW-1:0] w, input bit keep_valid,
                           input logic [DW-1:0] next_w, input bit inject,
                           input string name);
    int  bad, first_bad, done_at, toggles, exp_toggles, firsts_bad, budget;
    logic prev;
    bad = 0; first_bad = -1; done_at = -1; toggles = 0; exp_toggles = 0;
    firsts_bad = 0; budget = 0; prev = 1'b0;
    while (din_ready !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait din_ready=%b required 1", name, din_ready);
      return;
    end
    datain = w;
    din_valid = 1'b1;
    tick();
    datain = next_w;
    din_valid = keep_valid;
    for (int n = 1; n <= FRAME_CYC; n++) begin
      int   bi, k;
      logic eb, et;
      bi = (n - 1) / BC;
      k  = (n - 1) % BC;
      eb = exp_bit(w, bi);
      et = exp_tone(eb, k);
      if (dataout !== et || busy !== 1'b1 || din_ready !== 1'b0) begin
        if (bad == 0) first_bad = n;
        bad++;
      end
      if (frame_done === 1'b1) begin
        if (done_at < 0) done_at = n;
        else bad++;
      end
      if (k == 0) begin
        if (dataout !== 1'b1) firsts_bad++;
        exp_toggles += BC / (eb ? HM : HS) - 1;
      end else if (dataout !== prev) begin
        toggles++;
      end
      prev = dataout;
      if (inject) begin
        if (n == 300) begin
          datain = 8'hFF;
          din_valid = 1'b1;
        end else if (n == 304) begin
          din_valid = 1'b0;
        end
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s waveform bad_cycles=%0d first_at=%0d required 0", name, bad, first_bad);
    end
    checks++;
    if (done_at != FRAME_CYC) begin
      errors++;
      $display("FAIL %s frame_done_cycle got=%0d required %0d", name, done_at, FRAME_CYC);
    end
    checks++;
    if (toggles != exp_toggles) begin
      errors++;
      $display("FAIL %s toggle_count got=%0d required %0d", name, toggles, exp_toggles);
    end
    checks++;
    if (firsts_bad != 0) begin
      errors++;
      $display("FAIL %s bit_first_high bad_bits=%0d required 0", name, firsts_bad);
    end
    checks++;
    if (dataout !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_cycle dataout=%b busy=%b din_ready=%b frame_done=%b required 0 0 1 0",
               name, dataout, busy, din_ready, frame_done);
    end
    $display("frame %s word=%h bits=%0d frame_done_at=%0d toggles=%0d", name, w, NBITS, done_at, toggles);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    din_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (dataout !== 1'b0) begin errors++; $display("FAIL reset_dataout got=%b required 0", dataout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b required 0", frame_done); end
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got=%b required 0", din_ready); end
    reset = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early got=%b required 0", din_ready); end
    tick();
    checks++;
    if (din_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_ready got din_ready=%b busy=%b required 1 0", din_ready, busy);
    end
    $display("reset released din_ready=%b busy=%b", din_ready, busy);
  endtask

  task automatic test_a5;
    run_frame(8'hA5, 1'b0, 8'h00, 1'b0, "a5");
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] w;
      w = DW'($urandom_range(0, 255));
      run_frame(w, 1'b0, 8'h00, 1'b0, "random");
    end
  endtask

  task automatic test_odd_word;
    run_frame(8'h03, 1'b0, 8'h00, 1'b0, "w03");
  endtask

  task automatic test_back_to_back;
    run_frame(8'h00, 1'b1, 8'h01, 1'b0, "b2b_first");
    run_frame(8'h01, 1'b0, 8'h00, 1'b0, "b2b_second");
  endtask

  task automatic test_ignore_valid;
    int busy_seen;
    logic [DW-1:0] w;
    w = DW'($urandom_range(0, 255));
    run_frame(w, 1'b0, 8'h00, 1'b1, "ignore_ff");
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || dataout !== 1'b0) busy_seen++;
      tick();
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL ignore_extra_frame busy_cycles=%0d required 0", busy_seen);
    end
    $display("ignore check after frame busy_cycles=%0d", busy_seen);
  endtask

  task automatic test_mid_reset;
    int n, act;
    logic [DW-1:0] w;
    w = DW'($urandom_range(0, 255));
    datain = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n = 1;
    while ((n < 500 || exp_tone(exp_bit(w, (n - 1) / BC), (n - 1) % BC) != 1'b1) && n < 700) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b1 || dataout !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre busy=%b dataout=%b required 1 1", busy, dataout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dataout !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async dataout=%b busy=%b din_ready=%b frame_done=%b required 0 0 0 0",
               dataout, busy, din_ready, frame_done);
    end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready got=%b required 1", din_ready);
    end
    act = 0;
    for (int i = 0; i < 2 * BC; i++) begin
      if (busy !== 1'b0 || dataout !== 1'b0 || frame_done !== 1'b0) act++;
      tick();
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL midreset_no_resume active_cycles=%0d required 0", act);
    end
    $display("mid-frame reset word=%h at cycle %0d active_after=%0d", w, n, act);
  endtask

  initial begin
    test_reset();
    test_a5();
    test_odd_word();
    test_random();
    test_back_to_back();
    test_ignore_valid();
    test_mid_reset();
    test_a5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
